// File: rtl/axi_packet_gate.sv
// rtl/axi_packet_gate.sv - store-and-forward AXI-stream packet gate
// Only complete, error-free packets are released; errored or oversize packets are discarded whole.
module axi_packet_gate #(
  parameter int WIDTH = 64,
  parameter int SIZE  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_terror,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             drop
);

  typedef enum logic {WRITE, DROP} wstate_t;

  wstate_t         state;
  logic [SIZE-1:0] wr_addr;
  logic [SIZE-1:0] wr_base;
  logic [SIZE-1:0] rd_addr;
  logic [WIDTH:0]  mem [0:(1<<SIZE)-1];
  logic [WIDTH:0]  ram_q;
  logic            ram_valid;
  logic            flush;
  logic            full;
  logic            accept;
  logic            pop;
  logic            load;
  logic            fetch;

  assign flush    = reset | clear;
  assign full     = (wr_addr + SIZE'(1)) == rd_addr;
  assign i_tready = (state == DROP) | ~full;
  assign accept   = i_tvalid & i_tready;
  assign pop      = o_tvalid & o_tready;
  // ram_q is a second pipeline stage behind the output register, so a fetch
  // is safe whenever ram_q is empty or is moving into the output register.
  assign load     = ram_valid & (~o_tvalid | pop);
  assign fetch    = (rd_addr != wr_base) & (~ram_valid | load);

  always_ff @(posedge clk) begin
    if (!flush && state == WRITE && accept) begin
      mem[wr_addr] <= {i_tlast, i_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state   <= WRITE;
      wr_addr <= '0;
      wr_base <= '0;
      drop    <= 1'b0;
    end else begin
      drop <= 1'b0;
      case (state)
        WRITE: begin
          // The open packet occupies the whole RAM: it can never complete.
          if (full && rd_addr == wr_base) begin
            wr_addr <= wr_base;
            drop    <= 1'b1;
            state   <= DROP;
          end else if (accept) begin
            if (i_tlast && i_terror) begin
              wr_addr <= wr_base;
              drop    <= 1'b1;
            end else begin
              wr_addr <= wr_addr + SIZE'(1);
              if (i_tlast) begin
                wr_base <= wr_addr + SIZE'(1);
              end
            end
          end
        end
        DROP: begin
          if (accept && i_tlast) begin
            state <= WRITE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fetch) begin
      ram_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      rd_addr   <= '0;
      ram_valid <= 1'b0;
      o_tvalid  <= 1'b0;
    end else begin
      if (fetch) begin
        rd_addr <= rd_addr + SIZE'(1);
      end
      if (fetch) begin
        ram_valid <= 1'b1;
      end else if (load) begin
        ram_valid <= 1'b0;
      end
      if (load) begin
        o_tvalid <= 1'b1;
      end else if (pop) begin
        o_tvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      {o_tlast, o_tdata} <= ram_q;
    end
  end

endmodule

// File: tb/tb_axi_packet_gate.sv
// tb/tb_axi_packet_gate.sv - self-checking bench for axi_packet_gate
// Cycle-exact vector table for the basic paths, then multi-cycle sequences against a packet model.
module tb_axi_packet_gate;

  localparam int W = 16;
  localparam int S = 4;
  localparam int LIMIT = 2000;

  logic         clk;
  logic         reset;
  logic         clear;
  logic [W-1:0] i_tdata;
  logic         i_tlast;
  logic         i_terror;
  logic         i_tvalid;
  logic         i_tready;
  logic [W-1:0] o_tdata;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready;
  logic         drop;

  axi_packet_gate #(.WIDTH(W), .SIZE(S)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_terror(i_terror),
    .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         vld;
    logic [W-1:0] dat;
    logic         lst;
    logic         err;
    logic         rdy;
    logic         e_itr;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic         e_ol;
    logic         e_drop;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int drop_cnt = 0;
  int bubble_cnt = 0;
  bit prev_mid = 0;
  bit done = 0;
  logic [W:0] out_q[$];
  logic [W:0] exp_q[$];

  // Output monitor: records every transfer, counts drop pulses and mid-packet bubbles.
  always @(negedge clk) begin
    if (reset || clear) begin
      prev_mid = 0;
    end else begin
      if (prev_mid && o_tready && !o_tvalid) bubble_cnt++;
      if (o_tvalid && o_tready) begin
        out_q.push_back({o_tlast, o_tdata});
        prev_mid = !o_tlast;
      end
      if (drop) drop_cnt++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int vld, input int dat, input int lst, input int err,
                              input int ov, input int od, input int ol, input int dr);
    vec_t t;
    t.vld = vld[0]; t.dat = dat[W-1:0]; t.lst = lst[0]; t.err = err[0];
    t.rdy = 1'b1; t.e_itr = 1'b1;
    t.e_ov = ov[0]; t.e_od = od[W-1:0]; t.e_ol = ol[0]; t.e_drop = dr[0];
    return t;
  endfunction

  // Called and returns at posedge+1 with i_tvalid low.
  task automatic send(input logic [W-1:0] d, input logic l, input logic e, output int waits);
    i_tvalid = 1'b1; i_tdata = d; i_tlast = l; i_terror = e;
    waits = 0;
    while (!i_tready && waits < LIMIT) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= LIMIT) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: i_tready stayed 0 for %0d cycles, expected 1", waits);
    end
    @(posedge clk); #1;
    i_tvalid = 1'b0; i_tlast = 1'b0; i_terror = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_out(input int n);
    int c = 0;
    while (out_q.size() < n && c < LIMIT) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= LIMIT) begin
      n_vec++; n_err++;
      $display("FAIL wait_out_timeout: got %0d words expected %0d", out_q.size(), n);
    end
    idle(6);
  endtask

  task automatic cmp_q(input string name);
    int bad = 0;
    check({name, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      if (out_q[i] !== exp_q[i]) bad++;
    check({name, "_data"}, bad, 0);
  endtask

  vec_t tbl[20];

  initial begin
    int w, maxw, d0, len, exp_drops;
    logic err;
    logic [W-1:0] d;

    clk = 0; reset = 1; clear = 0;
    i_tvalid = 0; i_tdata = '0; i_tlast = 0; i_terror = 0; o_tready = 0;

    // 4-word good packet, then errored 3-word packet followed by good E0,E1.
    tbl[0]  = mk(1, 'hD000, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 'hD001, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 'hD002, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 'hD003, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 1, 'hD000, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1, 'hD001, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 1, 'hD002, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 'hD003, 1, 0);
    tbl[10] = mk(1, 'hBAD0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 'hBAD1, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 'hBAD2, 1, 1, 0, 0, 0, 0);
    tbl[13] = mk(1, 'hE000, 0, 0, 0, 0, 0, 1);
    tbl[14] = mk(1, 'hE001, 1, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 1, 'hE000, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 1, 'hE001, 1, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("reset_i_tready", i_tready, 1);
    check("reset_o_tvalid", o_tvalid, 0);
    check("reset_drop", drop, 0);

    for (int v = 0; v < 20; v++) begin
      @(posedge clk); #1;
      i_tvalid = tbl[v].vld; i_tdata = tbl[v].dat; i_tlast = tbl[v].lst;
      i_terror = tbl[v].err; o_tready = tbl[v].rdy;
      @(negedge clk);
      check($sformatf("v%0d_i_tready", v), i_tready, tbl[v].e_itr);
      check($sformatf("v%0d_o_tvalid", v), o_tvalid, tbl[v].e_ov);
      if (tbl[v].e_ov) begin
        check($sformatf("v%0d_o_tdata", v), o_tdata, tbl[v].e_od);
        check($sformatf("v%0d_o_tlast", v), o_tlast, tbl[v].e_ol);
      end
      check($sformatf("v%0d_drop", v), drop, tbl[v].e_drop);
    end
    @(posedge clk); #1;
    i_tvalid = 0; i_tlast = 0; i_terror = 0;
    idle(4);

    // Capacity: 15-word packet fits, i_tready falls after its last word.
    o_tready = 0; out_q.delete(); exp_q.delete(); maxw = 0;
    for (int i = 0; i < 15; i++) begin
      send(W'(16'h1100 + i), i == 14, 1'b0, w);
      exp_q.push_back({i == 14, W'(16'h1100 + i)});
      if (w > maxw) maxw = w;
    end
    check("cap15_no_wait", maxw, 0);
    check("cap15_full", i_tready, 0);
    o_tready = 1;
    wait_out(15);
    cmp_q("cap15");

    // 20-word packet overflows: one drop, rest swallowed, nothing output.
    out_q.delete(); d0 = drop_cnt; maxw = 0;
    for (int i = 0; i < 20; i++) begin
      send(W'(16'h2200 + i), i == 19, 1'b0, w);
      if (i >= 16 && w > maxw) maxw = w;
    end
    idle(6);
    check("ovf_drops", drop_cnt - d0, 1);
    check("ovf_swallow_ready", maxw, 0);
    check("ovf_no_output", out_q.size(), 0);

    // Random traffic against the packet model.
    out_q.delete(); exp_q.delete(); d0 = drop_cnt; exp_drops = 0; bubble_cnt = 0; done = 0;
    fork
      begin
        for (int p = 0; p < 200; p++) begin
          len = $urandom_range(1, 40);
          err = ($urandom_range(0, 9) == 0);
          for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            d = W'($urandom);
            send(d, i == len - 1, err && (i == len - 1), w);
            if (!err && len <= 15) exp_q.push_back({i == len - 1, d});
          end
          if (err || len > 15) exp_drops++;
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          o_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    o_tready = 1;
    wait_out(exp_q.size());
    cmp_q("rand");
    check("rand_drops", drop_cnt - d0, exp_drops);
    check("rand_no_bubble", bubble_cnt, 0);

    // Clear mid-packet with two committed packets buffered.
    o_tready = 0; out_q.delete();
    for (int i = 0; i < 3; i++) send(W'(16'h3300 + i), i == 2, 1'b0, w);
    for (int i = 0; i < 2; i++) send(W'(16'h3400 + i), i == 1, 1'b0, w);
    for (int i = 0; i < 2; i++) send(W'(16'h3500 + i), 1'b0, 1'b0, w);
    idle(3);
    check("pre_clear_o_tvalid", o_tvalid, 1);
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    check("clear_o_tvalid", o_tvalid, 0);
    check("clear_i_tready", i_tready, 1);
    o_tready = 1;
    idle(5);
    check("clear_nothing_left", out_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      send(W'(16'h3600 + i), i == 2, 1'b0, w);
      exp_q.push_back({i == 2, W'(16'h3600 + i)});
    end
    wait_out(3);
    cmp_q("post_clear");

    // Fill the buffer, then stream continuously across several pointer wraps.
    o_tready = 0; out_q.delete(); exp_q.delete();
    for (int p = 0; p < 12; p++) begin
      if (p == 3) o_tready = 1;
      for (int i = 0; i < 5; i++) begin
        send(W'(16'h4000 + p * 16 + i), i == 4, 1'b0, w);
        exp_q.push_back({i == 4, W'(16'h4000 + p * 16 + i)});
      end
    end
    wait_out(60);
    cmp_q("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/axi_packet_gate.md
Name: axi_packet_gate

Overview:
- Store-and-forward packet buffer that sits directly downstream of axi_fifo on the AXI-stream data path.
- Accepts words with tlast/terror and holds each packet until its last word arrives.
- Releases only complete, error-free packets; errored or oversize packets are discarded in full.
- Guarantees that downstream consumers (framers, DMA) never see a partial or bad packet and never stall mid-packet on an upstream bubble.

Parameters:
- WIDTH, 64, tdata width in bits.
- SIZE, 10, log2 of buffer depth in words (RAM of 2^SIZE x (WIDTH+1)); usable capacity is 2^SIZE-1 words.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- clear  input  1  synchronous flush, same effect as reset
- i_tdata  input  WIDTH  input data
- i_tlast  input  1  last word of packet
- i_terror  input  1  packet error flag, sampled only with i_tlast
- i_tvalid  input  1  input valid
- i_tready  output  1  input ready
- o_tdata  output  WIDTH  output data
- o_tlast  output  1  last word of packet
- o_tvalid  output  1  output valid
- o_tready  input  1  output ready
- drop  output  1  one-cycle pulse when a packet is discarded

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. clear has identical effect and priority over all other activity.
- Reset/clear values:
  - wr_addr = wr_base = rd_addr = 0; output register empty; write state WRITE.
  - o_tvalid = 0, drop = 0; i_tready = 1 from the first cycle after reset deasserts.
  - All buffered and partially written data is discarded, including reset mid-packet; o_tdata/o_tlast values are don't-care while o_tvalid = 0.
- Pointers: SIZE-bit, wrap modulo 2^SIZE.
  - wr_addr: next write location.
  - wr_base: first word of the packet being written, i.e. the commit point.
  - rd_addr: next RAM word to fetch.
- Full: wr_addr+1 == rd_addr. In WRITE, i_tready = ~full.
- Write state WRITE, on an accepted beat (i_tvalid & i_tready):
  - mem[wr_addr] <= {i_tlast, i_tdata}; wr_addr++.
  - If i_tlast & ~i_terror: wr_base <= wr_addr+1 (commit).
  - If i_tlast & i_terror: wr_addr <= wr_base (rewind); drop pulses the next cycle.
- Overflow, in WRITE: when full and rd_addr == wr_base (the current packet fills the whole RAM and no committed words remain):
  - wr_addr <= wr_base; drop pulses; go to DROP.
- Write state DROP:
  - i_tready = 1; all beats are discarded.
  - On an accepted beat with i_tlast, return to WRITE. i_terror is ignored.
- Read side:
  - RAM read latency is 1. A one-word output register, prefetched from RAM, drives o_tdata/o_tlast/o_tvalid.
  - A fetch is issued when rd_addr != wr_base and (the output register is empty, or will empty this cycle, or no fetch is in flight to fill it); rd_addr++ per fetch.
  - Sustained throughput is 1 word/cycle while o_tready = 1.
- Handshake: once o_tvalid = 1, o_tdata/o_tlast hold until o_tvalid & o_tready. Within a committed packet o_tvalid never deasserts mid-packet while o_tready is high.
- Latency: when the good tlast beat is accepted in cycle N, the commit is visible in N+1 and the packet's first word has o_tvalid = 1 no later than N+3, counting from an empty buffer.
- Simultaneous events:
  - A commit and a read in the same cycle are independent.
  - Reads of committed data proceed during DROP.
  - A write in the same cycle as a read that frees the full slot: i_tready is based on the registered full flag (no combinational o_tready -> i_tready path).
- Single-word packets (tlast on the first beat) are legal: they are committed or dropped the same as longer packets.
- Packets of exactly 2^SIZE-1 words are accepted when the buffer is otherwise empty. Any longer packet triggers overflow drop.

Test Plan:
- Reset, then a 4-word good packet D0..D3 with o_tready = 1 -> o_tvalid stays 0 until D3 is accepted, then D0..D3 emerge consecutively with o_tlast on D3 only, within 3 cycles of the tlast beat; drop stays 0.
- 3-word packet with i_terror = 1 on tlast, followed by a 2-word good packet E0,E1 -> only E0,E1 appear; drop pulses exactly once, 1 cycle after the errored tlast.
- SIZE = 4, o_tready = 0: a 15-word good packet -> accepted and i_tready falls to 0 after word 15; then o_tready = 1 -> all 15 words out in order. Repeat with 20 words -> drop pulse at word 16, remaining words swallowed with i_tready = 1, nothing output.
- Random o_tready (50%) and random i_tvalid over 200 packets of length 1-40 with 10% error packets -> the output stream equals the reference model of the good packets; o_tvalid never drops mid-packet when o_tready = 1.
- Assert clear mid-packet (2 committed packets buffered, third half written) -> next cycle o_tvalid = 0, i_tready = 1, and a subsequent new packet emerges alone.
- Full buffer with o_tready = 1 and i_tvalid = 1 continuously -> pointer wrap across address 2^SIZE-1 -> 0 with no lost or duplicated words over 3 full wraps.
